// File: rtl/seg7_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
// Segment words are active-low: {dp, g, f, e, d, c, b, a}.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [11:0] ALL_OFF = 12'hFFF;

    // Hex glyphs 0..F with dp off (bit 7 = 1).
    localparam logic [7:0] SEG_LUT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic logic [3:0] anode_onehot(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decoder with decimal point and blanking.
// A blanked digit keeps its dp so suppressed leading zeros can still carry a point.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    logic [7:0] glyph_s;

    // Look up the glyph, then apply blanking and the active-low dp.
    always_comb begin
        glyph_s = SEG_LUT[nibble];
        if (blank) begin
            seg = {~dp, 7'h7F};
        end else begin
            seg = {~dp, glyph_s[6:0]};
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode display scanner with double-buffered value,
// inter-digit blanking and tear-free frame-boundary updates.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_dp,
    input  logic        wr_lzs,
    output logic [11:0] o_data,
    output logic [1:0]  digit_idx,
    output logic        frame_done
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [1:0]       idx_r;
    logic [1:0]       idx_nxt_s;
    logic             done_nxt_s;

    logic [15:0]      shadow_data_r;
    logic [3:0]       shadow_dp_r;
    logic             shadow_lzs_r;
    logic [15:0]      act_data_r;
    logic [3:0]       act_dp_r;
    logic             act_lzs_r;

    logic [3:0]       nibble_s;
    logic             dp_s;
    logic             lz_s;
    logic [7:0]       seg_s;
    logic [11:0]      o_data_nxt_s;

    // Next-state, counter and digit index; enable low overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r + 1'b1;
        idx_nxt_s   = idx_r;
        done_nxt_s  = 1'b0;
        if (!enable) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = '0;
            idx_nxt_s   = 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = BLANK;
                    cnt_nxt_s   = '0;
                    idx_nxt_s   = 2'd0;
                end
                BLANK: begin
                    if (cnt_r == BLANK_LAST) begin
                        state_nxt_s = SHOW;
                        cnt_nxt_s   = '0;
                    end else begin
                        cnt_nxt_s   = cnt_r + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt_r == SHOW_LAST) begin
                        state_nxt_s = BLANK;
                        cnt_nxt_s   = '0;
                        idx_nxt_s   = idx_r + 2'd1;
                        done_nxt_s  = (idx_r == 2'd3);
                    end else begin
                        cnt_nxt_s   = cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = '0;
                    idx_nxt_s   = 2'd0;
                end
            endcase
        end
    end

    // Digit lit next: its nibble, dp and leading-zero blanking.
    always_comb begin
        nibble_s = act_data_r[{idx_nxt_s, 2'b00} +: 4];
        dp_s     = act_dp_r[idx_nxt_s];
        case (idx_nxt_s)
            2'd3:    lz_s = act_lzs_r && (act_data_r[15:12] == 4'h0);
            2'd2:    lz_s = act_lzs_r && (act_data_r[15:8] == 8'h00);
            2'd1:    lz_s = act_lzs_r && (act_data_r[15:4] == 12'h000);
            default: lz_s = 1'b0;
        endcase
    end

    seg7_hex_decode u_decode (
        .nibble (nibble_s),
        .dp     (dp_s),
        .blank  (lz_s),
        .seg    (seg_s)
    );

    // Display word for the upcoming state, so the output register tracks the state register.
    always_comb begin
        if (state_nxt_s == SHOW) begin
            o_data_nxt_s = {anode_onehot(idx_nxt_s), seg_s};
        end else begin
            o_data_nxt_s = ALL_OFF;
        end
    end

    // Scan FSM with registered display outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            idx_r      <= 2'd0;
            o_data     <= ALL_OFF;
            frame_done <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            idx_r      <= idx_nxt_s;
            o_data     <= o_data_nxt_s;
            frame_done <= done_nxt_s;
        end
    end

    // Shadow takes every write; active only changes as a frame ends, with write-through on that cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_data_r <= 16'h0000;
            shadow_dp_r   <= 4'h0;
            shadow_lzs_r  <= 1'b0;
            act_data_r    <= 16'h0000;
            act_dp_r      <= 4'h0;
            act_lzs_r     <= 1'b0;
        end else begin
            if (wr_en) begin
                shadow_data_r <= wr_data;
                shadow_dp_r   <= wr_dp;
                shadow_lzs_r  <= wr_lzs;
            end else begin
                shadow_data_r <= shadow_data_r;
                shadow_dp_r   <= shadow_dp_r;
                shadow_lzs_r  <= shadow_lzs_r;
            end
            if (done_nxt_s && wr_en) begin
                act_data_r <= wr_data;
                act_dp_r   <= wr_dp;
                act_lzs_r  <= wr_lzs;
            end else if (done_nxt_s) begin
                act_data_r <= shadow_data_r;
                act_dp_r   <= shadow_dp_r;
                act_lzs_r  <= shadow_lzs_r;
            end else begin
                act_data_r <= act_data_r;
                act_dp_r   <= act_dp_r;
                act_lzs_r  <= act_lzs_r;
            end
        end
    end

    assign digit_idx = idx_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with SCAN_DIV=4, BLANK_CYC=2 (24-cycle frames).
// Stimulus queues hand-computed digit words; a monitor pops one per newly lit digit.
module tb_seg7_scan_ctrl;

    localparam int FRAME = 24;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = 16'h0000;
    logic [3:0]  wr_dp = 4'h0;
    logic        wr_lzs = 1'b0;
    logic [11:0] o_data;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [13:0] exp_q[$];
    logic [11:0] prev_o = 12'hFFF;
    int          gap = 0;
    bit          have_done = 1'b0;

    seg7_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYC(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .wr_lzs     (wr_lzs),
        .o_data     (o_data),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [11:0] w0, input logic [11:0] w1,
                              input logic [11:0] w2, input logic [11:0] w3, input int n);
        if (n > 0) exp_q.push_back({2'd0, w0});
        if (n > 1) exp_q.push_back({2'd1, w1});
        if (n > 2) exp_q.push_back({2'd2, w2});
        if (n > 3) exp_q.push_back({2'd3, w3});
    endtask

    task automatic do_write(input logic [15:0] d, input logic [3:0] dp, input logic lzs);
        wr_data = d;
        wr_dp   = dp;
        wr_lzs  = lzs;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_done;
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL frame_done_timeout: no pulse within 60 cycles");
        end
    endtask

    // Monitor: every newly lit digit is checked against the head of the queue.
    always @(negedge clk) begin
        logic [13:0] e;
        if (reset && o_data != 12'hFFF && o_data != prev_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_digit", {digit_idx, o_data}, 16'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check("digit", {2'b00, digit_idx, o_data}, {2'b00, e});
            end
        end
        prev_o = o_data;
    end

    // Monitor: frame_done spacing while scanning continuously.
    always @(negedge clk) begin
        if (!reset || !enable) begin
            have_done = 1'b0;
            gap = 0;
        end else begin
            gap++;
            if (frame_done) begin
                if (have_done) check("frame_period", 16'(gap), 16'(FRAME));
                have_done = 1'b1;
                gap = 0;
            end
        end
    end

    initial begin
        // Reset held, then released with enable low.
        repeat (3) begin
            @(negedge clk);
            check("rst_o_data", {4'h0, o_data}, 16'h0FFF);
            check("rst_done", {15'h0, frame_done}, 16'h0000);
        end
        reset = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("idle_o_data", {4'h0, o_data}, 16'h0FFF);
            check("idle_idx", {14'h0, digit_idx}, 16'h0000);
            check("idle_done", {15'h0, frame_done}, 16'h0000);
        end

        // Basic scan: first frame shows reset contents, then 1234.
        do_write(16'h1234, 4'h0, 1'b0);
        enable = 1'b1;
        push_frame(12'hEC0, 12'hDC0, 12'hBC0, 12'h7C0, 4);
        wait_done();
        push_frame(12'hE99, 12'hDB0, 12'hBA4, 12'h7F9, 4);
        do_write(16'h0123, 4'b0101, 1'b0);
        wait_done();

        // Decode sweep with dp on digits 0 and 2.
        push_frame(12'hE30, 12'hDA4, 12'hB79, 12'h7C0, 4);
        do_write(16'h4567, 4'b0101, 1'b0);
        wait_done();
        push_frame(12'hE78, 12'hD82, 12'hB12, 12'h799, 4);
        do_write(16'h89AB, 4'b0101, 1'b0);
        wait_done();
        push_frame(12'hE03, 12'hD88, 12'hB10, 12'h780, 4);
        do_write(16'hCDEF, 4'b0101, 1'b0);
        wait_done();
        push_frame(12'hE0E, 12'hD86, 12'hB21, 12'h7C6, 4);
        do_write(16'h0050, 4'h0, 1'b1);
        wait_done();

        // Leading-zero suppression, including dp on a suppressed digit.
        push_frame(12'hEC0, 12'hD92, 12'hBFF, 12'h7FF, 4);
        do_write(16'h0000, 4'b1000, 1'b1);
        wait_done();
        push_frame(12'hEC0, 12'hDFF, 12'hBFF, 12'h77F, 4);
        do_write(16'h5555, 4'h0, 1'b0);
        wait_done();

        // Mid-frame write stays hidden until the next frame.
        push_frame(12'hE92, 12'hD92, 12'hB92, 12'h792, 4);
        repeat (10) @(negedge clk);
        do_write(16'hAAAA, 4'h0, 1'b0);
        wait_done();

        // Write-through on the boundary edge, then a write during the frame_done cycle.
        push_frame(12'hE88, 12'hD88, 12'hB88, 12'h788, 4);
        repeat (23) @(negedge clk);
        push_frame(12'hE8E, 12'hDC0, 12'hB8E, 12'h7FF, 4);
        wr_data = 16'h0F0F; wr_dp = 4'h0; wr_lzs = 1'b1; wr_en = 1'b1;
        @(negedge clk);
        check("boundary_done", {15'h0, frame_done}, 16'h0001);
        wr_data = 16'h2222; wr_dp = 4'h0; wr_lzs = 1'b0;
        @(negedge clk);
        wr_en = 1'b0;
        push_frame(12'hEA4, 12'hDA4, 12'hBA4, 12'h7A4, 4);
        wait_done();
        wait_done();

        // Enable drop during SHOW of digit 2.
        push_frame(12'hEA4, 12'hDA4, 12'hBA4, 12'h000, 3);
        repeat (15) @(negedge clk);
        check("pre_drop_idx", {14'h0, digit_idx}, 16'h0002);
        enable = 1'b0;
        @(negedge clk);
        check("drop_o_data", {4'h0, o_data}, 16'h0FFF);
        check("drop_idx", {14'h0, digit_idx}, 16'h0000);
        repeat (5) begin
            check("drop_done", {15'h0, frame_done}, 16'h0000);
            @(negedge clk);
        end

        // Asynchronous reset during SHOW of digit 2.
        enable = 1'b1;
        push_frame(12'hEA4, 12'hDA4, 12'hBA4, 12'h000, 3);
        repeat (16) @(negedge clk);
        check("pre_rst_idx", {14'h0, digit_idx}, 16'h0002);
        #1 reset = 1'b0;
        #1;
        check("async_rst_o_data", {4'h0, o_data}, 16'h0FFF);
        check("async_rst_idx", {14'h0, digit_idx}, 16'h0000);
        check("async_rst_done", {15'h0, frame_done}, 16'h0000);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_o_data", {4'h0, o_data}, 16'h0FFF);

        // Buffers were cleared by reset, so the restarted scan shows zeros.
        enable = 1'b1;
        push_frame(12'hEC0, 12'hDC0, 12'hBC0, 12'h7C0, 4);
        wait_done();
        enable = 1'b0;
        repeat (5) @(negedge clk);
        check("queue_drained", 16'(exp_q.size()), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
